// File: rtl/conv_encoder.sv
// ---------------------------------------------------------------------------
// conv_encoder
//
// Rate-1/r, constraint-length-K feed-forward convolutional encoder. Takes one
// information bit per input handshake and produces one registered r-bit
// codeword per output handshake. After the last information bit of a frame
// it appends K-1 zero tail bits so the trellis ends in state 0.
//
// Handshakes (both sides): a transfer happens in a cycle where valid and
// ready are both high. The producer keeps data stable while valid is high
// and ready is low. Valid never depends on ready. in_ready is combinational
// from code_valid, code_ready and the FSM state.
//
// Parameters:
//   r  code bits per input bit (codeword width), r >= 1
//   K  constraint length, K >= 2 (shift register holds K-1 bits)
//   G  packed generator tap masks; G[i*K +: K] drives code[i].
//      Bit K-1 of a mask taps the current bit, bit 0 the oldest history bit.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   in_bit      information bit
//   in_valid    in_bit / in_last valid
//   in_last     marks the final information bit of a frame
//   in_ready    encoder can accept an input bit this cycle
//   code        encoded codeword, code[i] from generator i
//   code_valid  code / code_last valid
//   code_ready  downstream accepts the codeword
//   code_last   codeword is the final tail symbol of the frame
//   busy        a frame is open (DATA or TAIL state)
// ---------------------------------------------------------------------------
module conv_encoder #(
   parameter int unsigned          r = 2,
   parameter int unsigned          K = 3,
   parameter logic [r*K-1:0]       G = 6'b101_111
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_bit,
   input  logic         in_valid,
   input  logic         in_last,
   output logic         in_ready,
   output logic [r-1:0] code,
   output logic         code_valid,
   input  logic         code_ready,
   output logic         code_last,
   output logic         busy
);

   localparam int TW = (K > 2) ? $clog2(K) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      TAIL = 2'd2
   } state_t;

   state_t          state_q,      state_d;
   logic [K-2:0]    sr_q,         sr_d;
   logic [TW-1:0]   tail_cnt_q,   tail_cnt_d;
   logic [r-1:0]    code_q,       code_d;
   logic            code_valid_q, code_valid_d;
   logic            code_last_q,  code_last_d;

   logic            slot_free;
   logic            fire_in;
   logic            fire_out;
   logic            load;
   logic            last_load;
   logic            b;
   logic [K-1:0]    w;
   logic [r-1:0]    code_new;

   // The output register can take a new word when it is empty or being
   // drained this cycle.
   assign slot_free = ~code_valid_q | code_ready;
   assign in_ready  = slot_free & (state_q != TAIL);
   assign fire_in   = in_valid & in_ready;
   assign fire_out  = code_valid_q & code_ready;

   always_comb begin
      state_d      = state_q;
      sr_d         = sr_q;
      tail_cnt_d   = tail_cnt_q;
      code_d       = code_q;
      code_valid_d = code_valid_q;
      code_last_d  = code_last_q;
      load         = 1'b0;
      last_load    = 1'b0;
      b            = 1'b0;
      w            = '0;
      code_new     = '0;

      case (state_q)
         IDLE, DATA: begin
            if (fire_in) begin
               load       = 1'b1;
               b          = in_bit;
               tail_cnt_d = '0;
               state_d    = in_last ? TAIL : DATA;
            end
         end
         TAIL: begin
            // Tail bits are zeros and only need room in the output register.
            if (slot_free) begin
               load = 1'b1;
               b    = 1'b0;
               if (tail_cnt_q == TW'(K - 2)) begin
                  last_load  = 1'b1;
                  tail_cnt_d = '0;
                  state_d    = IDLE;
               end else begin
                  tail_cnt_d = TW'(tail_cnt_q + 1'b1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Window: current bit on top, oldest history bit at w[0].
      w = {b, sr_q};
      for (int i = 0; i < int'(r); i++) begin
         code_new[i] = ^(w & G[i*K +: K]);
      end

      // A load takes priority over a drain in the same cycle.
      if (load) begin
         code_d       = code_new;
         code_valid_d = 1'b1;
         code_last_d  = last_load;
         sr_d         = w[K-1:1];
      end else if (fire_out) begin
         code_valid_d = 1'b0;
         code_last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         sr_q         <= '0;
         tail_cnt_q   <= '0;
         code_q       <= '0;
         code_valid_q <= 1'b0;
         code_last_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         sr_q         <= sr_d;
         tail_cnt_q   <= tail_cnt_d;
         code_q       <= code_d;
         code_valid_q <= code_valid_d;
         code_last_q  <= code_last_d;
      end
   end

   assign code       = code_q;
   assign code_valid = code_valid_q;
   assign code_last  = code_last_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_conv_encoder.sv
// ---------------------------------------------------------------------------
// tb_conv_encoder
//
// Directed bench for conv_encoder with default parameters (r=2, K=3,
// generators 7 and 5 octal). Expected codewords were worked out by hand from
// the window {b, sr}: code[0] = b^sr[1]^sr[0], code[1] = b^sr[0].
// ---------------------------------------------------------------------------
module tb_conv_encoder;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_bit = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_last = 1'b0;
   logic       in_ready;
   logic [1:0] code;
   logic       code_valid;
   logic       code_ready = 1'b0;
   logic       code_last;
   logic       busy;

   int n_checks = 0;
   int n_fails  = 0;

   // Scoreboard: {code_last, code}
   logic [2:0] exp_q[$];
   logic       bit_q[$];
   logic       last_q[$];

   conv_encoder dut (
      .clk        (clk),
      .rst        (rst),
      .in_bit     (in_bit),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .code       (code),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .code_last  (code_last),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic push_in(input logic b, input logic l);
      bit_q.push_back(b);
      last_q.push_back(l);
   endtask

   task automatic push_exp(input logic l, input logic [1:0] c);
      exp_q.push_back({l, c});
   endtask

   // Drives the queued input bits and drains the output, comparing every
   // accepted codeword. stall_mode=1 makes code_ready follow 1,0,0,1,0,0...
   task automatic run(input string tag, input bit stall_mode,
                      input int exp_last_cycle, input int exp_not_ready);
      int         c = 0;
      int         last_cycle = -1;
      int         not_ready = 0;
      bit         prev_stall = 1'b0;
      logic [1:0] held_code = '0;
      logic       held_last = 1'b0;
      logic [2:0] e;
      while (exp_q.size() > 0 && c < 200) begin
         code_ready = stall_mode ? (c % 3 == 0) : 1'b1;
         if (bit_q.size() > 0) begin
            in_valid = 1'b1;
            in_bit   = bit_q[0];
            in_last  = last_q[0];
         end else begin
            in_valid = 1'b0;
            in_bit   = 1'b0;
            in_last  = 1'b0;
         end
         #1;
         if (code_valid && prev_stall) begin
            chk({tag, "_hold_code"}, 32'(code), 32'(held_code));
            chk({tag, "_hold_last"}, 32'(code_last), 32'(held_last));
         end
         if (code_valid && code_ready) begin
            e = exp_q.pop_front();
            chk({tag, "_code"}, 32'(code), 32'(e[1:0]));
            chk({tag, "_last"}, 32'(code_last), 32'(e[2]));
            last_cycle = c;
         end
         if (!in_ready) not_ready++;
         if (in_valid && in_ready) begin
            void'(bit_q.pop_front());
            void'(last_q.pop_front());
         end
         prev_stall = code_valid && !code_ready;
         held_code  = code;
         held_last  = code_last;
         c++;
         next_cycle();
      end
      in_valid = 1'b0;
      in_bit   = 1'b0;
      in_last  = 1'b0;
      chk({tag, "_timeout_left"}, 32'(exp_q.size()), 32'd0);
      chk({tag, "_last_cycle"}, 32'(last_cycle), 32'(exp_last_cycle));
      chk({tag, "_in_not_ready_cycles"}, 32'(not_ready), 32'(exp_not_ready));
      chk({tag, "_no_extra"}, 32'(code_valid), 32'd0);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
      exp_q.delete();
      bit_q.delete();
      last_q.delete();
   endtask

   initial begin
      // Reset held with random inputs
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_bit     = 1'($urandom_range(0, 1));
         in_valid   = 1'($urandom_range(0, 1));
         in_last    = 1'($urandom_range(0, 1));
         code_ready = 1'($urandom_range(0, 1));
         next_cycle();
         chk("rst_code_valid", 32'(code_valid), 32'd0);
         chk("rst_code", 32'(code), 32'd0);
         chk("rst_code_last", 32'(code_last), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
      end
      in_valid   = 1'b0;
      in_bit     = 1'b0;
      in_last    = 1'b0;
      code_ready = 1'b0;
      rst        = 1'b1;
      next_cycle();
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_code_valid", 32'(code_valid), 32'd0);

      // Frame 1,0,1,1 with code_ready held high
      push_in(1, 0); push_in(0, 0); push_in(1, 0); push_in(1, 1);
      push_exp(0, 2'b11); push_exp(0, 2'b01); push_exp(0, 2'b00);
      push_exp(0, 2'b10); push_exp(0, 2'b10); push_exp(1, 2'b11);
      run("frame4", 1'b0, 6, 2);

      // Same frame with a stalling sink
      push_in(1, 0); push_in(0, 0); push_in(1, 0); push_in(1, 1);
      push_exp(0, 2'b11); push_exp(0, 2'b01); push_exp(0, 2'b00);
      push_exp(0, 2'b10); push_exp(0, 2'b10); push_exp(1, 2'b11);
      run("frame4_stall", 1'b1, 18, 14);

      // Single-bit frame
      push_in(1, 1);
      push_exp(0, 2'b11); push_exp(0, 2'b01); push_exp(1, 2'b11);
      run("single", 1'b0, 3, 2);

      // Back-to-back frames 1,0 and 1 with no bubble between them
      push_in(1, 0); push_in(0, 1); push_in(1, 1);
      push_exp(0, 2'b11); push_exp(0, 2'b01); push_exp(0, 2'b11);
      push_exp(1, 2'b00); push_exp(0, 2'b11); push_exp(0, 2'b01);
      push_exp(1, 2'b11);
      run("b2b", 1'b0, 7, 4);

      // Reset in the middle of a frame
      code_ready = 1'b1;
      in_valid   = 1'b1;
      in_bit     = 1'b1;
      in_last    = 1'b0;
      next_cycle();
      chk("mid_first_code", 32'(code), 32'(2'b11));
      in_bit = 1'b0;
      next_cycle();
      chk("mid_second_code", 32'(code), 32'(2'b01));
      chk("mid_busy", 32'(busy), 32'd1);
      in_valid = 1'b0;
      in_bit   = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_code_valid", 32'(code_valid), 32'd0);
      chk("mid_rst_code", 32'(code), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      next_cycle();
      rst = 1'b1;
      next_cycle();
      chk("mid_rst_no_tail", 32'(code_valid), 32'd0);
      push_in(1, 1);
      push_exp(0, 2'b11); push_exp(0, 2'b01); push_exp(1, 2'b11);
      run("after_rst", 1'b0, 3, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
